// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: RV32 funct3 size codes, FSM states, default parameters, byte-lane masks,
// and a size-legality helper.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_ADDR_W      = 32;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_B    = 4'b0001;
    localparam logic [3:0] LANE_H_LO = 4'b0011;
    localparam logic [3:0] LANE_H_HI = 4'b1100;
    localparam logic [3:0] LANE_W    = 4'b1111;

    // Unsigned sizes only make sense for loads.
    function automatic logic size_legal(input logic [2:0] size, input logic we);
        case (size)
            SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
            SZ_BU, SZ_HU:     size_legal = !we;
            default:          size_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a right-aligned CPU datum and a 32-bit RAM word.
// Latency: purely combinational.
// Backpressure: none; valid whenever its inputs are.
// Ports: size (funct3), off (already-aligned byte offset), wd (store data), rword (RAM word)
//        -> strb (byte write enables), wword (replicated store data), ldata (extended load data).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] rword,
    output logic [3:0]  strb,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        strb     = LANE_NONE;
        wword    = wd;
        ldata    = '0;
        byte_sel = rword[{off, 3'b000} +: 8];
        half_sel = off[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B, SZ_BU: begin
                strb  = LANE_B << off;
                wword = {4{wd[7:0]}};
                ldata = size[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H, SZ_HU: begin
                strb  = off[1] ? LANE_H_HI : LANE_H_LO;
                wword = {2{wd[15:0]}};
                ldata = size[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                strb  = LANE_W;
                wword = wd;
                ldata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data RAM for the MEM stage with RV32 load/store sizes.
// Latency: accept to RValid is WAIT_CYCLES+1 cycles; one access per WAIT_CYCLES+2 cycles.
// Backpressure: Ready is high only in IDLE; the request is held off until Ready.
// Ports: clk, rst (async active-low); Req/WE/Size/A/WD request; Ready, RValid/RD/Err response.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses report Err instead of aligning down.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req,
    input  logic              WE,
    input  logic [2:0]        Size,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    output logic              Ready,
    output logic              RValid,
    output logic [31:0]       RD,
    output logic              Err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              req_we;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_a;
    logic [31:0]       req_wd;
    logic [31:0]       rd_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept, enter_resp;
    logic              act_we;
    logic [2:0]        act_size;
    logic [ADDR_W-1:0] act_a;
    logic [31:0]       act_wd;
    logic              out_of_range, misalign, acc_err;
    logic [1:0]        off;
    logic [IDX_W-1:0]  widx;
    logic [3:0]        strb;
    logic [31:0]       wword, ldata;

    assign Ready      = rst && (state == ST_IDLE);
    assign RValid     = (state == ST_RESP);
    assign RD         = rd_q;
    assign Err        = err_q;
    assign accept     = Req && Ready;
    assign enter_resp = (state_nxt == ST_RESP);

    // With zero wait states the response is formed on the accepting edge itself,
    // before the request latch has been loaded, so use the live inputs while idle.
    assign act_we   = (state == ST_IDLE) ? WE   : req_we;
    assign act_size = (state == ST_IDLE) ? Size : req_size;
    assign act_a    = (state == ST_IDLE) ? A    : req_a;
    assign act_wd   = (state == ST_IDLE) ? WD   : req_wd;

    assign out_of_range = (act_a >> (IDX_W + 2)) != '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((act_size[1:0] == 2'b01) && act_a[0]) ||
                      ((act_size[1:0] == 2'b10) && (act_a[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign acc_err = out_of_range || !size_legal(act_size, act_we) || misalign;

    // Misaligned halves/words are aligned down; when trapping they are errored anyway.
    always_comb begin
        case (act_size[1:0])
            2'b10:   off = 2'b00;
            2'b01:   off = {act_a[1], 1'b0};
            default: off = act_a[1:0];
        endcase
    end

    assign widx = act_a[IDX_W+1:2];

    dmem_lane_align u_align (
        .size  (act_size),
        .off   (off),
        .wd    (act_wd),
        .rword (mem[widx]),
        .strb  (strb),
        .wword (wword),
        .ldata (ldata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 3'(WAIT_CYCLES - 1);
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) state_nxt = ST_RESP;
                else             cnt_nxt   = cnt - 3'd1;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            req_we   <= 1'b0;
            req_size <= '0;
            req_a    <= '0;
            req_wd   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_we   <= WE;
                req_size <= Size;
                req_a    <= A;
                req_wd   <= WD;
            end
            // Response data exists only for the single RESP cycle.
            if (enter_resp) begin
                err_q <= acc_err;
                rd_q  <= (act_we || acc_err) ? 32'd0 : ldata;
            end else begin
                err_q <= 1'b0;
                rd_q  <= '0;
            end
        end
    end

    // Only the two lowest words are cleared; the rest of the array keeps its contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (enter_resp && act_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu (one instance with 1 wait state, one with 3).
// Latency: each access checks accept-to-RValid distance.
// Backpressure: requests are only driven once Ready is seen.
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        rst1, rst3, req1, req3, we;
    logic [2:0]  size;
    logic [31:0] a, wd;
    logic        ready1, rvalid1, err1, ready3, rvalid3, err3;
    logic [31:0] rd1, rd3;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst1), .Req(req1), .WE(we), .Size(size), .A(a), .WD(wd),
        .Ready(ready1), .RValid(rvalid1), .RD(rd1), .Err(err1)
    );

    data_memory_lsu #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rst(rst3), .Req(req3), .WE(we), .Size(size), .A(a), .WD(wd),
        .Ready(ready3), .RValid(rvalid3), .RD(rd3), .Err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access on DUT d (0: 1 wait state, 1: 3 wait states).
    task automatic access(input bit d, input string tag, input logic w, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input logic exp_err);
        int n;
        n = 0;
        while (!(d ? ready3 : ready1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, d ? ready3 : ready1, 1);
        we = w; size = sz; a = addr; wd = data;
        if (d) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs so a design that fails to latch them is caught.
        req1 = 1'b0; req3 = 1'b0; we = ~w; size = 3'b111; a = 32'hFFFF_FFFF; wd = 32'h5A5A_A5A5;
        n = 1;
        while (!(d ? rvalid3 : rvalid1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, n, d ? 4 : 2);
        chk({tag, "_rvalid"}, d ? rvalid3 : rvalid1, 1);
        chk({tag, "_rd"}, d ? rd3 : rd1, exp_rd);
        chk({tag, "_err"}, d ? err3 : err1, exp_err);
        @(posedge clk); #1;
        chk({tag, "_rvalid_drop"}, d ? rvalid3 : rvalid1, 0);
    endtask

    initial begin
        rst1 = 1'b0; rst3 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; size = 3'b010; a = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready1, 0);
        chk("reset_rvalid", rvalid1, 0);
        chk("reset_rd", rd1, 0);
        chk("reset_err", err1, 0);
        chk("reset_ready3", ready3, 0);
        @(negedge clk);
        rst1 = 1'b1; rst3 = 1'b1;
        #1;
        chk("release_ready", ready1, 1);

        // Word store and load-back
        access(0, "sw_10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access(0, "lw_10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        // Byte stores and byte loads
        access(0, "sb_11", 1, 3'b000, 32'h11, 32'h7F, 32'h0, 0);
        access(0, "sb_12", 1, 3'b000, 32'h12, 32'h80, 32'h0, 0);
        access(0, "lw_10_b", 0, 3'b010, 32'h10, 32'h0, 32'hDE807FEF, 0);
        access(0, "lb_12", 0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF80, 0);
        access(0, "lbu_12", 0, 3'b100, 32'h12, 32'h0, 32'h00000080, 0);
        access(0, "lb_11", 0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 0);

        // Half stores and half loads
        access(0, "sw_20", 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0);
        access(0, "sh_22", 1, 3'b001, 32'h22, 32'h8001, 32'h0, 0);
        access(0, "lh_22", 0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0);
        access(0, "lhu_22", 0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0);
        access(0, "lh_20", 0, 3'b001, 32'h20, 32'h0, 32'h00003344, 0);
        access(0, "lw_20", 0, 3'b010, 32'h20, 32'h0, 32'h80013344, 0);

        // Errors: out of range, illegal size, unsigned store
        access(0, "lw_oor", 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1);
        access(0, "sz_011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        access(0, "sw_oor", 1, 3'b010, 32'h1000, 32'hAAAAAAAA, 32'h0, 1);
        access(0, "lw_0", 0, 3'b010, 32'h0, 32'h0, 32'h0, 0);
        access(0, "sbu_20", 1, 3'b100, 32'h20, 32'hFF, 32'h0, 1);
        access(0, "lw_20_b", 0, 3'b010, 32'h20, 32'h0, 32'h80013344, 0);

        // Misalignment
`ifdef DMEM_MISALIGN_TRAP_EN
        access(0, "sw_13", 1, 3'b010, 32'h13, 32'h12345678, 32'h0, 1);
        access(0, "lw_10_mis", 0, 3'b010, 32'h10, 32'h0, 32'hDE807FEF, 0);
        access(0, "lh_23", 0, 3'b001, 32'h23, 32'h0, 32'h0, 1);
`else
        access(0, "sw_13", 1, 3'b010, 32'h13, 32'h12345678, 32'h0, 0);
        access(0, "lw_10_mis", 0, 3'b010, 32'h10, 32'h0, 32'h12345678, 0);
        access(0, "lh_23", 0, 3'b001, 32'h23, 32'h0, 32'hFFFF8001, 0);
`endif

        // Reset abort during WAIT on the 3-wait-state instance
        access(1, "sw_30", 1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 0);
        we = 1'b1; size = 3'b010; a = 32'h30; wd = 32'h0BADBEEF; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b0;
        #1;
        chk("abort_rvalid", rvalid3, 0);
        chk("abort_ready", ready3, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_hold_rvalid", rvalid3, 0);
        end
        chk("abort_hold_ready", ready3, 0);
        rst3 = 1'b1;
        #1;
        chk("abort_release_ready", ready3, 1);
        access(1, "lw_30", 0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
